// File: rtl/mxint_divisor_repeat.sv
// Captures one MX divisor block (mantissas + shared exponent) and replays it REPEAT times.
// Define MXINT_DIVISOR_REPEAT_DOUBLE_BUF_EN for a second slot so groups hand off without bubbles.
module mxint_divisor_repeat #(
    parameter int MAN_WIDTH  = 8,
    parameter int EXP_WIDTH  = 8,
    parameter int BLOCK_SIZE = 4,
    parameter int REPEAT     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [MAN_WIDTH-1:0] mdata_in [BLOCK_SIZE],
    input  logic [EXP_WIDTH-1:0] edata_in,
    input  logic                 data_in_valid,
    output logic                 data_in_ready,
    output logic [MAN_WIDTH-1:0] mdata_out [BLOCK_SIZE],
    output logic [EXP_WIDTH-1:0] edata_out,
    output logic                 data_out_valid,
    input  logic                 data_out_ready,
    output logic                 data_out_last
);

`ifdef MXINT_DIVISOR_REPEAT_DOUBLE_BUF_EN
    localparam int NUM_SLOTS = 2;
`else
    localparam int NUM_SLOTS = 1;
`endif
    localparam int CNT_WIDTH = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(REPEAT - 1);

    logic [MAN_WIDTH-1:0] man_reg [NUM_SLOTS][BLOCK_SIZE];
    logic [EXP_WIDTH-1:0] exp_reg [NUM_SLOTS];
    logic                 full_reg [NUM_SLOTS];
    logic [CNT_WIDTH-1:0] rep_cnt_reg;
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic                 in_fire;
    logic                 out_fire;
    logic                 cnt_at_last;

    // Ready depends only on registered state, never on the valid/ready inputs.
    assign data_in_ready  = !full_reg[wr_ptr];
    assign in_fire        = data_in_valid && data_in_ready;
    assign data_out_valid = full_reg[rd_ptr];
    assign out_fire       = data_out_valid && data_out_ready;
    assign cnt_at_last    = (rep_cnt_reg == CNT_LAST);
    assign data_out_last  = data_out_valid && cnt_at_last;
    assign edata_out      = exp_reg[rd_ptr];

`ifdef MXINT_DIVISOR_REPEAT_DOUBLE_BUF_EN
    logic wr_ptr_reg;
    logic rd_ptr_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
        end else begin
            if (in_fire)
                wr_ptr_reg <= !wr_ptr_reg;
            if (out_fire && cnt_at_last)
                rd_ptr_reg <= !rd_ptr_reg;
        end
    end

    assign wr_ptr = wr_ptr_reg;
    assign rd_ptr = rd_ptr_reg;
`else
    assign wr_ptr = 1'b0;
    assign rd_ptr = 1'b0;
`endif

    generate
        for (genvar gi = 0; gi < BLOCK_SIZE; gi++) begin : g_out
            assign mdata_out[gi] = man_reg[rd_ptr][gi];
        end

        // A load always targets an empty slot and a release a full one, so they never collide.
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    full_reg[gi] <= 1'b0;
                    exp_reg[gi]  <= '0;
                    for (int bi = 0; bi < BLOCK_SIZE; bi++)
                        man_reg[gi][bi] <= '0;
                end else if (in_fire && (wr_ptr == 1'(gi))) begin
                    full_reg[gi] <= 1'b1;
                    exp_reg[gi]  <= edata_in;
                    for (int bi = 0; bi < BLOCK_SIZE; bi++)
                        man_reg[gi][bi] <= mdata_in[bi];
                end else if (out_fire && cnt_at_last && (rd_ptr == 1'(gi))) begin
                    full_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt_reg <= '0;
        end else if (out_fire) begin
            if (cnt_at_last)
                rep_cnt_reg <= '0;
            else
                rep_cnt_reg <= rep_cnt_reg + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_mxint_divisor_repeat.sv
// Bench for mxint_divisor_repeat: scoreboard of replayed beats, vector table, corner sequences.
// Follows MXINT_DIVISOR_REPEAT_DOUBLE_BUF_EN for the back-to-back timing expectations.
`timescale 1ns/1ps
module tb_mxint_divisor_repeat;
    localparam int MW = 8;
    localparam int EW = 8;
    localparam int BS = 4;
    localparam int RP = 8;

    typedef struct packed {
        logic [BS*MW-1:0] man;
        logic [EW-1:0]    exp;
        logic             last;
    } beat_t;

    typedef struct {
        logic [BS*MW-1:0] man;
        logic [EW-1:0]    exp;
        int               pct;
        int               beats;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [MW-1:0] mdata_in [BS];
    logic [EW-1:0] edata_in;
    logic          data_in_valid;
    logic          data_in_ready;
    logic [MW-1:0] mdata_out [BS];
    logic [EW-1:0] edata_out;
    logic          data_out_valid;
    logic          data_out_ready;
    logic          data_out_last;

    beat_t sb_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    fire_cnt = 0;
    int    ready_pct = 100;

    mxint_divisor_repeat #(
        .MAN_WIDTH(MW), .EXP_WIDTH(EW), .BLOCK_SIZE(BS), .REPEAT(RP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mdata_in(mdata_in),
        .edata_in(edata_in),
        .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready),
        .mdata_out(mdata_out),
        .edata_out(edata_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready),
        .data_out_last(data_out_last)
    );

    always #5 clk = ~clk;

    function automatic logic [BS*MW-1:0] pack_m(input logic [MW-1:0] m [BS]);
        logic [BS*MW-1:0] r;
        for (int i = 0; i < BS; i++) r[i*MW +: MW] = m[i];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Caller is at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic load_block(input logic [BS*MW-1:0] m, input logic [EW-1:0] e);
        int t = 0;
        for (int i = 0; i < BS; i++) mdata_in[i] = m[i*MW +: MW];
        edata_in = e;
        data_in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (data_in_ready) break;
            t++;
            if (t > 200) begin
                n_vec++; n_err++;
                $display("FAIL load_timeout: data_in_ready stayed 0, expected 1 within 200 cycles");
                break;
            end
        end
        @(posedge clk);
        #1;
        data_in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc);
        int t = 0;
        forever begin
            @(negedge clk);
            if (sb_q.size() == 0 && !data_out_valid) break;
            t++;
            if (t > max_cyc) begin
                n_vec++; n_err++;
                $display("FAIL drain_timeout: %0d beats still pending, expected 0", sb_q.size());
                sb_q.delete();
                break;
            end
        end
    endtask

    // Downstream ready generator.
    initial begin
        data_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            data_out_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    // Monitor: reset checks, stall stability, scoreboard pop on output, push on input accept.
    initial begin
        beat_t exp_b;
        beat_t held;
        logic  stall_prev;
        stall_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_valid", 64'(data_out_valid), 64'd0);
                check("rst_last", 64'(data_out_last), 64'd0);
                check("rst_in_ready", 64'(data_in_ready), 64'd1);
                check("rst_data", 64'({pack_m(mdata_out), edata_out}), 64'd0);
                sb_q.delete();
                stall_prev = 1'b0;
            end else begin
                if (stall_prev)
                    check("stall_hold",
                          64'({data_out_valid, pack_m(mdata_out), edata_out, data_out_last}),
                          64'({1'b1, held}));
                if (data_out_valid && data_out_ready) begin
                    fire_cnt++;
                    if (sb_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_beat: got %0h/%0h last=%0b, expected no beat",
                                 pack_m(mdata_out), edata_out, data_out_last);
                    end else begin
                        exp_b = sb_q.pop_front();
                        check("beat", 64'({pack_m(mdata_out), edata_out, data_out_last}), 64'(exp_b));
                    end
                end
                stall_prev = data_out_valid && !data_out_ready;
                held = {pack_m(mdata_out), edata_out, data_out_last};
                if (data_in_valid && data_in_ready)
                    for (int i = 0; i < RP; i++)
                        sb_q.push_back({pack_m(mdata_in), edata_in, (i == RP - 1)});
            end
        end
    end

    initial begin
        vec_t vecs[6];
        int   base;
        int   t;
        int   fires[$];
        bit   chk_next;

        vecs[0] = '{man: 32'hDEADBEEF, exp: 8'h7F, pct: 100, beats: RP};
        vecs[1] = '{man: 32'h00000000, exp: 8'h00, pct: 30,  beats: RP};
        vecs[2] = '{man: 32'hFFFFFFFF, exp: 8'hFF, pct: 30,  beats: RP};
        vecs[3] = '{man: 32'h80017F81, exp: 8'h80, pct: 70,  beats: RP};
        vecs[4] = '{man: 32'h12345678, exp: 8'h01, pct: 50,  beats: RP};
        vecs[5] = '{man: 32'hA5C3965A, exp: 8'hFE, pct: 30,  beats: RP};

        // Reset held 3 cycles with random inputs.
        data_in_valid = 1'b0;
        edata_in = '0;
        for (int i = 0; i < BS; i++) mdata_in[i] = '0;
        repeat (3) begin
            sync();
            for (int i = 0; i < BS; i++) mdata_in[i] = MW'($urandom);
            edata_in = EW'($urandom);
            data_in_valid = 1'($urandom_range(0, 1));
        end
        rst = 1'b0;
        data_in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_valid", 64'(data_out_valid), 64'd0);
        check("post_rst_last", 64'(data_out_last), 64'd0);
        check("post_rst_in_ready", 64'(data_in_ready), 64'd1);
        check("post_rst_data", 64'({pack_m(mdata_out), edata_out}), 64'd0);

        // Single group {1,2,3,4}/5: first beat one cycle after load.
        sync();
        base = fire_cnt;
        load_block(32'h04030201, 8'd5);
        @(negedge clk);
        check("first_beat_latency", 64'(data_out_valid), 64'd1);
        check("first_beat_data", 64'({pack_m(mdata_out), edata_out}), 64'h0403020105);
        wait_drain(100);
        check("single_beats", 64'(fire_cnt - base), 64'(RP));
        check("idle_after_group", 64'(data_out_valid), 64'd0);

        // Table-driven groups under varied backpressure.
        for (int v = 0; v < 6; v++) begin
            ready_pct = vecs[v].pct;
            sync();
            base = fire_cnt;
            load_block(vecs[v].man, vecs[v].exp);
            wait_drain(400);
            check("vec_beats", 64'(fire_cnt - base), 64'(vecs[v].beats));
        end
        ready_pct = 100;
        sync();
        sync();

        // Back-to-back groups A then B.
        chk_next = 1'b0;
        fires.delete();
        fork
            begin
                load_block(32'h11223344, 8'h0A);
                load_block(32'h55667788, 8'h0B);
                @(negedge clk);
                check("ready_low_after_b", 64'(data_in_ready), 64'd0);
            end
            begin
                for (int c = 0; c < 80 && fires.size() < 16; c++) begin
                    @(negedge clk);
                    if (chk_next) begin
                        check("ready_rise_after_a", 64'(data_in_ready), 64'd1);
                        chk_next = 1'b0;
                    end
                    if (data_out_valid && data_out_ready) begin
                        fires.push_back(c);
                        if (fires.size() == 8) begin
                            check("ready_low_at_a_last", 64'(data_in_ready), 64'd0);
                            chk_next = 1'b1;
                        end
                    end
                end
            end
        join
        check("b2b_beats", 64'(fires.size()), 64'd16);
        if (fires.size() == 16) begin
`ifdef MXINT_DIVISOR_REPEAT_DOUBLE_BUF_EN
            check("b2b_no_gap", 64'(fires[15] - fires[0]), 64'd15);
`else
            check("b2b_gap", 64'(fires[8] - fires[7] >= 2), 64'd1);
`endif
        end
        wait_drain(100);

        // Reset after beat 3 of A with B offered/queued, then a normal group C.
        sync();
        base = fire_cnt;
        load_block(32'hCAFEF00D, 8'h21);
        for (int i = 0; i < BS; i++) mdata_in[i] = MW'(8'h60 + i);
        edata_in = 8'h22;
        data_in_valid = 1'b1;
        t = 0;
        while (fire_cnt - base < 3 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("midrst_beat3_reached", 64'(fire_cnt - base), 64'd3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        data_in_valid = 1'b0;
        repeat (2) sync();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("post_midrst_idle", 64'(data_out_valid), 64'd0);
        end
        check("post_midrst_in_ready", 64'(data_in_ready), 64'd1);
        sync();
        base = fire_cnt;
        load_block(32'h0F0E0D0C, 8'h33);
        wait_drain(100);
        check("group_c_beats", 64'(fire_cnt - base), 64'(RP));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
